hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard and flush sequencer for the 5-stage RV64I core. It decodes the ID-stage instruction's source-register usage and compares it against the EX-stage load destination. It generates the PC/IF-ID write enables, the IF-ID flush and the ID-EX bubble, and holds load-use stalls for a configurable number of cycles. It also owns the global pipeline freeze for memory wait, and optionally keeps hazard performance counters.

Parameters:
STALL_CYCLES, 1, bubbles inserted per load-use hazard (legal 1..15)
CNT_W, 32, width of performance counters

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous active-high reset
id_instr_i  input  32  instruction currently in IF/ID
ex_memread_i  input  1  EX-stage instruction is a load
ex_rd_i  input  5  EX-stage destination register
branch_taken_i  input  1  EX-stage branch resolved taken (PC redirect this cycle)
mem_busy_i  input  1  data/instr memory not ready; freeze whole pipeline
pc_write_o  output  1  PC register load enable
ifid_write_o  output  1  IF/ID register load enable
ifid_flush_o  output  1  IF/ID loads NOP
idex_bubble_o  output  1  ID/EX loads all-zero control (bubble)
pipe_hold_o  output  1  all pipeline registers hold
state_o  output  2  FSM state: 0 RUN, 1 STALL
stall_cnt_o  output  CNT_W  load-use bubbles inserted
flush_cnt_o  output  CNT_W  taken-branch flushes

Behaviour:
- Clock and reset: single clock clk_i; rst_i synchronous, active-high.
- Source-use decode, from id_instr_i[6:0]:
  - 0110011 (R), 0100011 (S), 1100011 (B): use rs1=[19:15] and rs2=[24:20].
  - 0010011 (I-ALU), 0000011 (load): use rs1 only.
  - All other opcodes: no sources.
- hazard = ex_memread_i && ex_rd_i!=0 && ((use_rs1 && rs1==ex_rd_i) || (use_rs2 && rs2==ex_rd_i)).
- State: registered FSM {RUN, STALL} plus a 4-bit countdown cnt. Control outputs are combinational from state and inputs, giving zero-latency response.
- Priority, highest first: rst_i > mem_busy_i > branch_taken_i > STALL > hazard.
- While rst_i=1:
  - pc_write_o=0, ifid_write_o=0, ifid_flush_o=1, idex_bubble_o=1, pipe_hold_o=0.
  - Next state RUN, cnt=0, counters 0. Reset mid-stall aborts the stall.
- mem_busy_i=1 (freeze):
  - pipe_hold_o=1, pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=0.
  - state, cnt and counters hold.
  - A branch_taken_i or hazard coincident with freeze is ignored this cycle; it is re-evaluated when freeze drops, since inputs are held by the frozen pipeline.
- branch_taken_i=1:
  - pc_write_o=1, ifid_write_o=1, ifid_flush_o=1, idex_bubble_o=1.
  - Next state RUN, cnt=0 (aborts any stall). flush_cnt_o +1.
- STALL:
  - pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.
  - cnt decrements; at cnt==1 next state RUN.
  - No new hazard detection in STALL.
- RUN with hazard:
  - Same outputs as STALL this cycle; stall_cnt_o +1.
  - STALL_CYCLES==1: stay RUN.
  - Otherwise: next STALL, cnt=STALL_CYCLES-1.
  - stall_cnt_o also increments once per STALL-state cycle, so total = bubbles inserted.
- RUN, no event: pc_write_o=1, ifid_write_o=1, ifid_flush_o=0, idex_bubble_o=0, pipe_hold_o=0.
- state_o reflects the registered state.
- Counters saturate at all-ones (no wrap).

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: stall_cnt_o and flush_cnt_o implemented as above.
- Undefined: counter registers are not built; both outputs are tied to 0. Control behaviour is identical.

Test Plan:
- Load-use: STALL_CYCLES=1, ex_memread_i=1, ex_rd_i=5, id_instr_i=0x002280B3 (add x1,x5,x2) -> same cycle pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; next cycle (ex_memread_i=0) all enables 1; stall_cnt_o=1.
- No false stalls:
  - ex_rd_i=0 with id_instr_i using rs1=0 -> no stall.
  - id_instr_i=0x002282B7 (lui, bits 19:15=5) with ex_rd_i=5 -> no stall.
  - ex_memread_i=0 -> no stall.
- Store rs2 hazard: id_instr_i=0x0050A023 (sw x5,0(x1)), ex_rd_i=5, ex_memread_i=1 -> stall asserted; with STALL_CYCLES=3, exactly 3 consecutive bubble cycles, state_o=1 for cycles 2-3, stall_cnt_o=3.
- Branch priority: hazard and branch_taken_i=1 in the same cycle -> ifid_flush_o=1, idex_bubble_o=1, pc_write_o=1, no stall, flush_cnt_o=1, stall_cnt_o=0; branch_taken_i in cycle 2 of a 3-cycle stall -> stall aborted, state_o=0 next cycle.
- Freeze: STALL_CYCLES=3, mem_busy_i=1 for 4 cycles starting in STALL cycle 2 -> pipe_hold_o=1, all enables 0, cnt/state frozen; after release exactly 2 more bubble cycles remain.
- Reset: rst_i=1 mid-STALL -> next cycle state_o=0, counters 0; during reset ifid_flush_o=1, idex_bubble_o=1, pc_write_o=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / taken-branch / memory-freeze hazard sequencer for the 5-stage RV64I core.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters (tied to zero otherwise).
module hazard_ctrl #(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      id_instr_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             branch_taken_i,
  input  logic             mem_busy_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             pipe_hold_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1
  } state_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  // The hazard cycle itself is the first bubble, so the countdown covers the rest.
  localparam logic [3:0] STALL_INIT = 4'(STALL_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [6:0] opcode_s;
  logic [4:0] rs1_s, rs2_s;
  logic       use_rs1_s, use_rs2_s, hazard_s;
  logic       stall_inc_s, flush_inc_s;
  logic       unused_instr_s;

  assign opcode_s       = id_instr_i[6:0];
  assign rs1_s          = id_instr_i[19:15];
  assign rs2_s          = id_instr_i[24:20];
  assign unused_instr_s = ^{id_instr_i[31:25], id_instr_i[14:7]};

  // Which register fields the ID-stage opcode actually reads.
  always_comb begin
    use_rs1_s = 1'b0;
    use_rs2_s = 1'b0;
    case (opcode_s)
      OP_R, OP_S, OP_B: begin
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
      end
      OP_IALU, OP_LOAD: begin
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b0;
      end
      default: begin
        use_rs1_s = 1'b0;
        use_rs2_s = 1'b0;
      end
    endcase
  end

  assign hazard_s = ex_memread_i && (ex_rd_i != 5'd0) &&
                    ((use_rs1_s && (rs1_s == ex_rd_i)) || (use_rs2_s && (rs2_s == ex_rd_i)));

  // Prioritised control decode: reset > freeze > branch flush > stall > new hazard.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stall_inc_s   = 1'b0;
    flush_inc_s   = 1'b0;
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_hold_o   = 1'b0;
    if (rst_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
      state_d       = ST_RUN;
      cnt_d         = 4'd0;
    end else if (mem_busy_i) begin
      pipe_hold_o  = 1'b1;
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
    end else if (branch_taken_i) begin
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
      state_d       = ST_RUN;
      cnt_d         = 4'd0;
      flush_inc_s   = 1'b1;
    end else if (state_q == ST_STALL) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
      stall_inc_s   = 1'b1;
      if (cnt_q <= 4'd1) begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
      end else begin
        state_d = ST_STALL;
        cnt_d   = cnt_q - 4'd1;
      end
    end else if (hazard_s) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
      stall_inc_s   = 1'b1;
      if (STALL_CYCLES > 1) begin
        state_d = ST_STALL;
        cnt_d   = STALL_INIT;
      end else begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
      end
    end else begin
      state_d = ST_RUN;
      cnt_d   = cnt_q;
    end
  end

  // FSM state and countdown registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating hazard counters; freeze holds them because the increments are gated off.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      if (stall_inc_s && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      if (flush_inc_s && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + CNT_ONE;
      end else begin
        flush_cnt_q <= flush_cnt_q;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  logic unused_perf_s;
  assign unused_perf_s = stall_inc_s ^ flush_inc_s;
  assign stall_cnt_o   = {CNT_W{1'b0}};
  assign flush_cnt_o   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1-cycle and 3-cycle stalls, 3-bit counters on the latter)
// share stimulus; directed scenarios plus random traffic against a bubble-count reference model.
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst, ex_memread, branch_taken, mem_busy;
  logic [31:0] id_instr;
  logic [4:0]  ex_rd;

  logic        pc_a, ifw_a, fl_a, bub_a, hold_a, pc_b, ifw_b, fl_b, bub_b, hold_b;
  logic [1:0]  st_a, st_b;
  logic [31:0] scnt_a, fcnt_a;
  logic [2:0]  scnt_b, fcnt_b;
  logic [6:0]  ctl_a, ctl_b;

  int errors = 0;
  int checks = 0;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [31:0] ADD_X1_X5_X2 = 32'h002280B3;
  localparam logic [31:0] SW_X5_X1     = 32'h0050A023;
  localparam logic [31:0] LUI_X5       = 32'h002282B7;
  localparam logic [31:0] ADDI_X1_X0   = 32'h00100093;
  localparam logic [31:0] NOP          = 32'h00000013;
  // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}
  localparam logic [4:0] C_RUN = 5'b11000, C_BUB = 5'b00010, C_FLUSH = 5'b11110;
  localparam logic [4:0] C_FRZ = 5'b00001, C_RST = 5'b00110;

  hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(32)) dut_a (
    .clk_i(clk), .rst_i(rst), .id_instr_i(id_instr), .ex_memread_i(ex_memread), .ex_rd_i(ex_rd),
    .branch_taken_i(branch_taken), .mem_busy_i(mem_busy), .pc_write_o(pc_a), .ifid_write_o(ifw_a),
    .ifid_flush_o(fl_a), .idex_bubble_o(bub_a), .pipe_hold_o(hold_a), .state_o(st_a),
    .stall_cnt_o(scnt_a), .flush_cnt_o(fcnt_a));

  hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .id_instr_i(id_instr), .ex_memread_i(ex_memread), .ex_rd_i(ex_rd),
    .branch_taken_i(branch_taken), .mem_busy_i(mem_busy), .pc_write_o(pc_b), .ifid_write_o(ifw_b),
    .ifid_flush_o(fl_b), .idex_bubble_o(bub_b), .pipe_hold_o(hold_b), .state_o(st_b),
    .stall_cnt_o(scnt_b), .flush_cnt_o(fcnt_b));

  assign ctl_a = {pc_a, ifw_a, fl_a, bub_a, hold_a, st_a};
  assign ctl_b = {pc_b, ifw_b, fl_b, bub_b, hold_b, st_b};

  always #5 clk = ~clk;

  // Reference model: remaining bubbles after this cycle, and saturating event counts.
  int     rem[2]   = '{0, 0};
  longint mscnt[2] = '{0, 0};
  longint mfcnt[2] = '{0, 0};
  int     scv[2]   = '{1, 3};
  longint maxv[2]  = '{64'hFFFF_FFFF, 64'd7};

  function automatic logic hz_ref(input logic [31:0] ins, input logic mr, input logic [4:0] rd);
    int nsrc;
    case (ins[6:0])
      7'h33, 7'h23, 7'h63: nsrc = 2;
      7'h13, 7'h03:        nsrc = 1;
      default:             nsrc = 0;
    endcase
    if (!mr || rd == 5'd0) return 1'b0;
    if (nsrc >= 1 && ins[19:15] == rd) return 1'b1;
    if (nsrc == 2 && ins[24:20] == rd) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [6:0] ctl_ref(input int k);
    logic [1:0] st;
    st = (rem[k] > 0) ? 2'd1 : 2'd0;
    if (rst) return {C_RST, st};
    if (mem_busy) return {C_FRZ, st};
    if (branch_taken) return {C_FLUSH, st};
    if (rem[k] > 0 || hz_ref(id_instr, ex_memread, ex_rd)) return {C_BUB, st};
    return {C_RUN, st};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic mr, input logic [4:0] rd,
                       input logic br, input logic busy, input logic r);
    id_instr = ins; ex_memread = mr; ex_rd = rd; branch_taken = br; mem_busy = busy; rst = r;
    #2;
  endtask

  task automatic tick();
    logic hz;
    hz = hz_ref(id_instr, ex_memread, ex_rd);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        rem[k] = 0; mscnt[k] = 0; mfcnt[k] = 0;
      end else if (mem_busy) begin
        rem[k] = rem[k];
      end else if (branch_taken) begin
        rem[k] = 0;
        if (mfcnt[k] < maxv[k]) mfcnt[k]++;
      end else if (rem[k] > 0) begin
        rem[k]--;
        if (mscnt[k] < maxv[k]) mscnt[k]++;
      end else if (hz) begin
        rem[k] = scv[k] - 1;
        if (mscnt[k] < maxv[k]) mscnt[k]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_reset();
    drive(ADD_X1_X5_X2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
    checks++; if (ctl_a !== {C_RST, 2'd0}) begin errors++; $display("FAIL reset_ctl_a got=%b want=%b", ctl_a, {C_RST, 2'd0}); end
    checks++; if (ctl_b !== {C_RST, 2'd0}) begin errors++; $display("FAIL reset_ctl_b got=%b want=%b", ctl_b, {C_RST, 2'd0}); end
    checks++; if (scnt_a !== 32'd0 || fcnt_a !== 32'd0) begin errors++; $display("FAIL reset_cnt_a got=%0d/%0d want=0/0", scnt_a, fcnt_a); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(ADD_X1_X5_X2, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    checks++; if (ctl_a !== {C_BUB, 2'd0}) begin errors++; $display("FAIL lu_bubble got=%b want=%b", ctl_a, {C_BUB, 2'd0}); end
    tick();
    drive(ADD_X1_X5_X2, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
    checks++; if (ctl_a !== {C_RUN, 2'd0}) begin errors++; $display("FAIL lu_resume got=%b want=%b", ctl_a, {C_RUN, 2'd0}); end
    checks++; if (scnt_a !== (PERF ? 32'd1 : 32'd0)) begin errors++; $display("FAIL lu_stall_cnt got=%0d want=%0d", scnt_a, PERF ? 1 : 0); end
    checks++; if (st_b !== 2'd1) begin errors++; $display("FAIL lu_state_b got=%0d want=1", st_b); end
    tick();
  endtask

  task automatic test_no_false_stall();
    logic [31:0] ins [3] = '{ADDI_X1_X0, LUI_X5, ADD_X1_X5_X2};
    logic [4:0]  rds [3] = '{5'd0, 5'd5, 5'd5};
    logic        mrs [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      do_reset();
      drive(ins[i], mrs[i], rds[i], 1'b0, 1'b0, 1'b0);
      checks++; if (ctl_a !== {C_RUN, 2'd0}) begin errors++; $display("FAIL nofalse_a[%0d] got=%b want=%b", i, ctl_a, {C_RUN, 2'd0}); end
      checks++; if (ctl_b !== {C_RUN, 2'd0}) begin errors++; $display("FAIL nofalse_b[%0d] got=%b want=%b", i, ctl_b, {C_RUN, 2'd0}); end
      tick();
    end
  endtask

  task automatic test_store_rs2();
    logic [6:0] want [4] = '{{C_BUB, 2'd0}, {C_BUB, 2'd1}, {C_BUB, 2'd1}, {C_RUN, 2'd0}};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(SW_X5_X1, (c < 3) ? 1'b1 : 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
      checks++; if (ctl_b !== want[c]) begin errors++; $display("FAIL store_cyc%0d got=%b want=%b", c + 1, ctl_b, want[c]); end
      tick();
    end
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (scnt_b !== (PERF ? 3'd3 : 3'd0)) begin errors++; $display("FAIL store_stall_cnt got=%0d want=%0d", scnt_b, PERF ? 3 : 0); end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    drive(ADD_X1_X5_X2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    checks++; if (ctl_a !== {C_FLUSH, 2'd0}) begin errors++; $display("FAIL br_prio_a got=%b want=%b", ctl_a, {C_FLUSH, 2'd0}); end
    checks++; if (ctl_b !== {C_FLUSH, 2'd0}) begin errors++; $display("FAIL br_prio_b got=%b want=%b", ctl_b, {C_FLUSH, 2'd0}); end
    tick();
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (ctl_b !== {C_RUN, 2'd0}) begin errors++; $display("FAIL br_nostall got=%b want=%b", ctl_b, {C_RUN, 2'd0}); end
    checks++; if (fcnt_a !== (PERF ? 32'd1 : 32'd0) || scnt_a !== 32'd0) begin errors++; $display("FAIL br_cnt got=%0d/%0d want=%0d/0", fcnt_a, scnt_a, PERF ? 1 : 0); end
    drive(ADD_X1_X5_X2, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    tick();
    drive(ADD_X1_X5_X2, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    checks++; if (ctl_b !== {C_FLUSH, 2'd1}) begin errors++; $display("FAIL br_in_stall got=%b want=%b", ctl_b, {C_FLUSH, 2'd1}); end
    tick();
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (ctl_b !== {C_RUN, 2'd0}) begin errors++; $display("FAIL br_abort got=%b want=%b", ctl_b, {C_RUN, 2'd0}); end
    checks++; if (fcnt_b !== (PERF ? 3'd2 : 3'd0) || scnt_b !== (PERF ? 3'd1 : 3'd0)) begin errors++; $display("FAIL br_abort_cnt got=%0d/%0d want=%0d/%0d", fcnt_b, scnt_b, PERF ? 2 : 0, PERF ? 1 : 0); end
    tick();
  endtask

  task automatic test_freeze();
    logic [6:0] want [3] = '{{C_BUB, 2'd1}, {C_BUB, 2'd1}, {C_RUN, 2'd0}};
    do_reset();
    drive(SW_X5_X1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(SW_X5_X1, 1'b1, 5'd5, c[0], 1'b1, 1'b0);
      checks++; if (ctl_b !== {C_FRZ, 2'd1}) begin errors++; $display("FAIL freeze_b[%0d] got=%b want=%b", c, ctl_b, {C_FRZ, 2'd1}); end
      checks++; if (ctl_a !== {C_FRZ, 2'd0}) begin errors++; $display("FAIL freeze_a[%0d] got=%b want=%b", c, ctl_a, {C_FRZ, 2'd0}); end
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      checks++; if (ctl_b !== want[c]) begin errors++; $display("FAIL freeze_after[%0d] got=%b want=%b", c, ctl_b, want[c]); end
      tick();
    end
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (scnt_b !== (PERF ? 3'd3 : 3'd0)) begin errors++; $display("FAIL freeze_stall_cnt got=%0d want=%0d", scnt_b, PERF ? 3 : 0); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(SW_X5_X1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    tick();
    drive(SW_X5_X1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    checks++; if (ctl_b !== {C_RST, 2'd1}) begin errors++; $display("FAIL rst_mid got=%b want=%b", ctl_b, {C_RST, 2'd1}); end
    tick();
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (ctl_b !== {C_RUN, 2'd0}) begin errors++; $display("FAIL rst_abort got=%b want=%b", ctl_b, {C_RUN, 2'd0}); end
    checks++; if (scnt_b !== 3'd0 || fcnt_b !== 3'd0) begin errors++; $display("FAIL rst_cnt got=%0d/%0d want=0/0", scnt_b, fcnt_b); end
    tick();
  endtask

  task automatic test_random();
    logic [6:0] ops [8] = '{7'h33, 7'h23, 7'h63, 7'h13, 7'h03, 7'h37, 7'h6F, 7'h67};
    logic [31:0] ins;
    logic [6:0]  ea, eb;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 7)];
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      drive(ins, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 199) == 0));
      ea = ctl_ref(0);
      eb = ctl_ref(1);
      checks++; if (ctl_a !== ea) begin errors++; $display("FAIL rnd_ctl_a n=%0d got=%b want=%b", n, ctl_a, ea); end
      checks++; if (ctl_b !== eb) begin errors++; $display("FAIL rnd_ctl_b n=%0d got=%b want=%b", n, ctl_b, eb); end
      checks++; if (longint'(scnt_a) !== (PERF ? mscnt[0] : 64'd0) || longint'(fcnt_a) !== (PERF ? mfcnt[0] : 64'd0)) begin
        errors++; $display("FAIL rnd_cnt_a n=%0d got=%0d/%0d want=%0d/%0d", n, scnt_a, fcnt_a, PERF ? mscnt[0] : 0, PERF ? mfcnt[0] : 0);
      end
      checks++; if (longint'(scnt_b) !== (PERF ? mscnt[1] : 64'd0) || longint'(fcnt_b) !== (PERF ? mfcnt[1] : 64'd0)) begin
        errors++; $display("FAIL rnd_cnt_b n=%0d got=%0d/%0d want=%0d/%0d", n, scnt_b, fcnt_b, PERF ? mscnt[1] : 0, PERF ? mfcnt[1] : 0);
      end
      tick();
    end
  endtask

  initial begin
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    tick();
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_store_rs2();
    test_branch();
    test_freeze();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
